sstv_tone_decoder: RTL

SSTV_TONE_DECODER -- requirements
Module: sstv_tone_decoder

---
 rtl/sstv_tone_decoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sstv_tone_decoder.sv
// SSTV tone decoder: measures the period of the synchronised audio square
// wave, qualifies a run of 1200 Hz sync periods, then samples a luminance
// value derived from the tone period once per pixel slot across one line.
// FSM state is exposed on state_dbg so checkers can bind to it directly.
//
// Handshake/strobe semantics: px_valid, line_start and err are registered,
// single-cycle pulses with no back-pressure; px_data is stable from the
// px_valid cycle until the next px_valid.
module sstv_tone_decoder #(
    parameter int scanline_width = 320,
    parameter int px_per_line    = scanline_width * 3,
    parameter int SYNC_MIN       = 80000,
    parameter int SYNC_MAX       = 86800,
    parameter int SYNC_COUNT     = 4,
    parameter int BLACK_PERIOD   = 66667,
    parameter int GAIN           = 721,
    parameter int PIXEL_CYCLES   = 45600,
    parameter int TIMEOUT        = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       audio_in,
    output logic [7:0] px_data,
    output logic       px_valid,
    output logic       line_start,
    output logic [8:0] line_count,
    output logic       err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LINE = 2'd2
    } state_t;

    localparam int PIXEL_LAST = PIXEL_CYCLES - 1;
    localparam int PX_LAST    = px_per_line - 1;

    localparam logic [19:0] SYNC_MIN_C   = SYNC_MIN[19:0];
    localparam logic [19:0] SYNC_MAX_C   = SYNC_MAX[19:0];
    localparam logic [19:0] BLACK_C      = BLACK_PERIOD[19:0];
    localparam logic [19:0] TIMEOUT_C    = TIMEOUT[19:0];
    localparam logic [19:0] PIXEL_LAST_C = PIXEL_LAST[19:0];
    localparam logic [31:0] GAIN_C       = GAIN[31:0];
    localparam logic [15:0] PX_LAST_C    = PX_LAST[15:0];
    localparam logic [7:0]  SYNC_COUNT_C = SYNC_COUNT[7:0];

    logic        sync1, sync2, sync3;
    logic        rise;
    logic [19:0] period_cnt;
    logic [19:0] period;
    logic        timeout;
    logic        in_sync_range;
    logic        sync_per;
    logic        other_per;

    logic [19:0] diff;
    logic [51:0] prod;
    logic [35:0] scaled;
    logic [7:0]  luma_next;
    logic [7:0]  luma_reg;

    state_t      state, state_next;
    logic [7:0]  sync_cnt, sync_cnt_next;
    logic [15:0] px_cnt, px_cnt_next;
    logic [19:0] pix_timer, timer_next;
    logic [7:0]  px_data_next;
    logic        px_valid_next, line_start_next, err_next;
    logic [8:0]  line_count_next;
    logic        tc;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= audio_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise    = sync2 & ~sync3;
    assign timeout = (period_cnt == TIMEOUT_C);

    // The value latched into period on an edge is period_cnt in the same
    // cycle, so classifying period_cnt here classifies that period.
    assign in_sync_range = (period_cnt >= SYNC_MIN_C) && (period_cnt <= SYNC_MAX_C);
    assign sync_per      = rise & in_sync_range;
    assign other_per     = rise & ~in_sync_range;

    // Period counter: saturates at the timeout, restarts at 1 on each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= 20'd0;
            period     <= 20'd0;
        end else if (!ena) begin
            period_cnt <= 20'd0;
        end else if (rise) begin
            period     <= period_cnt;
            period_cnt <= 20'd1;
        end else if (period_cnt < TIMEOUT_C) begin
            period_cnt <= period_cnt + 20'd1;
        end
    end

    // Luminance from the latched period: shorter period means brighter.
    always_comb begin
        diff      = BLACK_C - period;
        prod      = 52'(diff) * 52'(GAIN_C);
        scaled    = 36'(prod >> 16);
        luma_next = 8'd0;
        if (period < BLACK_C) begin
            luma_next = (|scaled[35:8]) ? 8'hFF : scaled[7:0];
        end
    end

    // Registered multiply result; lands two cycles after the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            luma_reg <= 8'd0;
        end else begin
            luma_reg <= luma_next;
        end
    end

    assign tc = (pix_timer == PIXEL_LAST_C);

    // Next-state and strobe decisions; a timeout outranks any edge.
    always_comb begin
        state_next      = state;
        sync_cnt_next   = sync_cnt;
        px_cnt_next     = px_cnt;
        timer_next      = pix_timer;
        px_data_next    = px_data;
        px_valid_next   = 1'b0;
        line_start_next = 1'b0;
        err_next        = 1'b0;
        line_count_next = line_count;
        if (!ena) begin
            state_next    = HUNT;
            sync_cnt_next = 8'd0;
            px_cnt_next   = 16'd0;
            timer_next    = 20'd0;
        end else begin
            case (state)
                HUNT: begin
                    if (sync_per) begin
                        state_next    = SYNC;
                        sync_cnt_next = 8'd1;
                    end
                end
                SYNC: begin
                    if (timeout) begin
                        err_next      = 1'b1;
                        state_next    = HUNT;
                        sync_cnt_next = 8'd0;
                    end else if (sync_per) begin
                        if (sync_cnt != 8'hFF) begin
                            sync_cnt_next = sync_cnt + 8'd1;
                        end
                    end else if (other_per) begin
                        sync_cnt_next = 8'd0;
                        if (sync_cnt >= SYNC_COUNT_C) begin
                            state_next      = LINE;
                            line_start_next = 1'b1;
                            timer_next      = 20'd0;
                            px_cnt_next     = 16'd0;
                        end else begin
                            state_next = HUNT;
                        end
                    end
                end
                LINE: begin
                    if (timeout) begin
                        err_next    = 1'b1;
                        state_next  = HUNT;
                        px_cnt_next = 16'd0;
                        timer_next  = 20'd0;
                    end else if (sync_per) begin
                        // Sync inside a line: drop the partial line and
                        // start qualifying the new sync run right away.
                        err_next      = 1'b1;
                        state_next    = SYNC;
                        sync_cnt_next = 8'd1;
                        px_cnt_next   = 16'd0;
                        timer_next    = 20'd0;
                    end else if (tc) begin
                        px_data_next  = luma_reg;
                        px_valid_next = 1'b1;
                        timer_next    = 20'd0;
                        if (px_cnt == PX_LAST_C) begin
                            state_next      = HUNT;
                            px_cnt_next     = 16'd0;
                            line_count_next = line_count + 9'd1;
                        end else begin
                            px_cnt_next = px_cnt + 16'd1;
                        end
                    end else begin
                        timer_next = pix_timer + 20'd1;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            sync_cnt   <= 8'd0;
            px_cnt     <= 16'd0;
            pix_timer  <= 20'd0;
            px_data    <= 8'd0;
            px_valid   <= 1'b0;
            line_start <= 1'b0;
            err        <= 1'b0;
            line_count <= 9'd0;
        end else begin
            state      <= state_next;
            sync_cnt   <= sync_cnt_next;
            px_cnt     <= px_cnt_next;
            pix_timer  <= timer_next;
            px_data    <= px_data_next;
            px_valid   <= px_valid_next;
            line_start <= line_start_next;
            err        <= err_next;
            line_count <= line_count_next;
        end
    end

    assign state_dbg = state;

endmodule
